// File: rtl/ibex_counter_scheduler.sv
// Performance-counter bank that shares one adder across counters. A round-robin slot folds each
// counter's pending event count into its stored value. Optional overflow flags: IBEX_COUNTER_SCHED_OVF_EN.
module ibex_counter_scheduler #(
  parameter int unsigned  NumCounters  = 4,
  parameter int unsigned  CounterWidth = 64,
  parameter int unsigned  PendW        = $clog2(NumCounters) + 1,
  localparam int unsigned IdxW         = $clog2(NumCounters)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumCounters-1:0] event_i,
  input  logic [NumCounters-1:0] inhibit_i,
  input  logic [IdxW-1:0]        csr_idx_i,
  input  logic                   csr_we_i,
  input  logic                   csr_weh_i,
  input  logic [31:0]            csr_wdata_i,
  output logic [63:0]            csr_rdata_o,
  output logic [IdxW-1:0]        slot_o,
  input  logic [NumCounters-1:0] ovf_clr_i,
  output logic [NumCounters-1:0] ovf_o,
  output logic                   irq_o
);

  localparam logic [PendW-1:0] PendMax = '1;

  logic [CounterWidth-1:0] cnt_q  [NumCounters];
  logic [PendW-1:0]        pend_q [NumCounters];
  logic [IdxW-1:0]         slot_q;

  logic [NumCounters-1:0] ev;
  logic                   idx_valid;
  logic                   wr_en;
  logic                   add_en;
  logic [63:0]            cur64;
  logic [63:0]            wr_val64;
  logic [CounterWidth:0]  sum;

  assign ev        = event_i & ~inhibit_i;
  assign idx_valid = 32'(csr_idx_i) < NumCounters;
  assign wr_en     = (csr_we_i | csr_weh_i) & idx_valid;
  // A CSR write to the counter being serviced wins; its scheduled add is dropped.
  assign add_en    = ~(wr_en && (csr_idx_i == slot_q));

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cur64 = '0;
    if (idx_valid) cur64 = 64'(cnt_q[csr_idx_i]);
  end

  // High-half write takes priority when both write strobes are set.
  assign wr_val64    = csr_weh_i ? {csr_wdata_i, cur64[31:0]} : {cur64[63:32], csr_wdata_i};
  assign csr_rdata_o = cur64;
  assign slot_o      = slot_q;

  // Single shared adder; the extra top bit is the carry-out used as overflow.
  assign sum = {1'b0, cnt_q[slot_q]} + (CounterWidth+1)'(pend_q[slot_q]);

  // NOTE: sequential state uses non-blocking assignments only; the counter array is reset
  // because its contents are architecturally visible through the CSR read port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q <= '0;
      for (int i = 0; i < NumCounters; i++) begin
        cnt_q[i]  <= '0;
        pend_q[i] <= '0;
      end
    end else begin
      slot_q <= (slot_q == IdxW'(NumCounters - 1)) ? '0 : slot_q + 1'b1;
      for (int i = 0; i < NumCounters; i++) begin
        if (wr_en && (csr_idx_i == IdxW'(i))) begin
          cnt_q[i]  <= CounterWidth'(wr_val64);
          pend_q[i] <= '0;
        end else if (slot_q == IdxW'(i)) begin
          cnt_q[i]  <= sum[CounterWidth-1:0];
          pend_q[i] <= PendW'(ev[i]);
        end else if (pend_q[i] != PendMax) begin
          pend_q[i] <= pend_q[i] + PendW'(ev[i]);
        end
      end
    end
  end

`ifdef IBEX_COUNTER_SCHED_OVF_EN
  logic [NumCounters-1:0] ovf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NumCounters; i++) begin
        ovf_q[i] <= (ovf_q[i] & ~ovf_clr_i[i]) |
                    (add_en && (slot_q == IdxW'(i)) && sum[CounterWidth]);
      end
    end
  end

  assign ovf_o = ovf_q;
  assign irq_o = |ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^{ovf_clr_i, sum[CounterWidth], add_en};
  assign ovf_o      = '0;
  assign irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_counter_scheduler.sv
// Directed testbench for ibex_counter_scheduler (default NumCounters=4, CounterWidth=64).
module tb_ibex_counter_scheduler;

  localparam int NumCounters = 4;
  localparam int IdxW        = 2;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [NumCounters-1:0] event_i;
  logic [NumCounters-1:0] inhibit_i;
  logic [IdxW-1:0]        csr_idx_i;
  logic                   csr_we_i;
  logic                   csr_weh_i;
  logic [31:0]            csr_wdata_i;
  logic [63:0]            csr_rdata_o;
  logic [IdxW-1:0]        slot_o;
  logic [NumCounters-1:0] ovf_clr_i;
  logic [NumCounters-1:0] ovf_o;
  logic                   irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  ibex_counter_scheduler dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .event_i     (event_i),
    .inhibit_i   (inhibit_i),
    .csr_idx_i   (csr_idx_i),
    .csr_we_i    (csr_we_i),
    .csr_weh_i   (csr_weh_i),
    .csr_wdata_i (csr_wdata_i),
    .csr_rdata_o (csr_rdata_o),
    .slot_o      (slot_o),
    .ovf_clr_i   (ovf_clr_i),
    .ovf_o       (ovf_o),
    .irq_o       (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance n clock edges, leaving the bench 1ns after the last rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Select a counter and return its read value; writes must be idle when this is used.
  task automatic read_cnt(input int idx, output logic [63:0] val);
    csr_idx_i = IdxW'(idx);
    #1;
    val = csr_rdata_o;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] v;
    event_i = '1;
    step(3);
    event_i = '0;
    apply_reset();
    n_tests++;
    if (slot_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_slot: got %0d expected 0", slot_o);
    end
    n_tests++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got %b expected 0", irq_o);
    end
    n_tests++;
    if (ovf_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b expected 0000", ovf_o);
    end
    for (int i = 0; i < NumCounters; i++) begin
      read_cnt(i, v);
      n_tests++;
      if (v !== 64'd0) begin
        n_fail++;
        $display("FAIL reset_cnt%0d: got 0x%h expected 0", i, v);
      end
    end
    // Slot pointer walks 1,2,3,0,1 after reset.
    for (int k = 1; k <= 5; k++) begin
      step(1);
      n_tests++;
      if (slot_o !== IdxW'(k % NumCounters)) begin
        n_fail++;
        $display("FAIL slot_walk%0d: got %0d expected %0d", k, slot_o, k % NumCounters);
      end
    end
  endtask

  task automatic test_event_accum();
    logic [63:0] v;
    event_i = 4'b0100;
    step(10);
    event_i = '0;
    step(5);
    read_cnt(2, v);
    n_tests++;
    if (v !== 64'd10) begin
      n_fail++;
      $display("FAIL accum_cnt2: got %0d expected 10", v);
    end
    read_cnt(0, v);
    n_tests++;
    if (v !== 64'd0) begin
      n_fail++;
      $display("FAIL accum_cnt0: got %0d expected 0", v);
    end
  endtask

  task automatic test_inhibit();
    logic [63:0] v;
    inhibit_i = 4'b0010;
    event_i   = 4'b0010;
    step(8);
    event_i = '0;
    step(5);
    inhibit_i = '0;
    read_cnt(1, v);
    n_tests++;
    if (v !== 64'd0) begin
      n_fail++;
      $display("FAIL inhibit_cnt1: got %0d expected 0", v);
    end
    step(5);
    read_cnt(1, v);
    n_tests++;
    if (v !== 64'd0) begin
      n_fail++;
      $display("FAIL inhibit_pend1: got %0d expected 0", v);
    end
    read_cnt(2, v);
    n_tests++;
    if (v !== 64'd10) begin
      n_fail++;
      $display("FAIL inhibit_cnt2: got %0d expected 10", v);
    end
  endtask

  task automatic test_csr_write();
    logic [63:0] v;
    for (int k = 0; k < 8 && slot_o != 2'd0; k++) step(1);
    n_tests++;
    if (slot_o !== 2'd0) begin
      n_fail++;
      $display("FAIL write_slot_sync: got %0d expected 0", slot_o);
    end
    csr_idx_i   = 2'd0;
    csr_we_i    = 1'b1;
    csr_wdata_i = 32'hDEAD_BEEF;
    event_i     = 4'b0001;
    step(1);
    csr_we_i = 1'b0;
    event_i  = '0;
    read_cnt(0, v);
    n_tests++;
    if (v !== 64'h0000_0000_DEAD_BEEF) begin
      n_fail++;
      $display("FAIL write_low: got 0x%h expected 0x00000000deadbeef", v);
    end
    step(5);
    read_cnt(0, v);
    n_tests++;
    if (v !== 64'h0000_0000_DEAD_BEEF) begin
      n_fail++;
      $display("FAIL write_ev_dropped: got 0x%h expected 0x00000000deadbeef", v);
    end
    csr_idx_i   = 2'd0;
    csr_weh_i   = 1'b1;
    csr_wdata_i = 32'h0000_0001;
    step(1);
    csr_weh_i = 1'b0;
    read_cnt(0, v);
    n_tests++;
    if (v !== 64'h0000_0001_DEAD_BEEF) begin
      n_fail++;
      $display("FAIL write_high: got 0x%h expected 0x00000001deadbeef", v);
    end
    // Both strobes: only the high half changes.
    csr_idx_i   = 2'd0;
    csr_we_i    = 1'b1;
    csr_weh_i   = 1'b1;
    csr_wdata_i = 32'h0000_0005;
    step(1);
    csr_we_i  = 1'b0;
    csr_weh_i = 1'b0;
    read_cnt(0, v);
    n_tests++;
    if (v !== 64'h0000_0005_DEAD_BEEF) begin
      n_fail++;
      $display("FAIL write_both: got 0x%h expected 0x00000005deadbeef", v);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] v;
    csr_idx_i   = 2'd3;
    csr_we_i    = 1'b1;
    csr_wdata_i = 32'hFFFF_FFFE;
    step(1);
    csr_we_i    = 1'b0;
    csr_weh_i   = 1'b1;
    csr_wdata_i = 32'hFFFF_FFFF;
    step(1);
    csr_weh_i = 1'b0;
    read_cnt(3, v);
    n_tests++;
    if (v !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_fail++;
      $display("FAIL ovf_preload: got 0x%h expected 0xfffffffffffffffe", v);
    end
    event_i = 4'b1000;
    step(3);
    event_i = '0;
    step(6);
    read_cnt(3, v);
    n_tests++;
    if (v !== 64'd1) begin
      n_fail++;
      $display("FAIL ovf_wrap: got 0x%h expected 0x1", v);
    end
`ifdef IBEX_COUNTER_SCHED_OVF_EN
    n_tests++;
    if (ovf_o !== 4'b1000) begin
      n_fail++;
      $display("FAIL ovf_flag: got %b expected 1000", ovf_o);
    end
    n_tests++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_irq: got %b expected 1", irq_o);
    end
    ovf_clr_i = 4'b1000;
    step(1);
    ovf_clr_i = '0;
    n_tests++;
    if (ovf_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b expected 0000", ovf_o);
    end
    n_tests++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_irq_clear: got %b expected 0", irq_o);
    end
`else
    n_tests++;
    if (ovf_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL ovf_flag_off: got %b expected 0000", ovf_o);
    end
    n_tests++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_irq_off: got %b expected 0", irq_o);
    end
`endif
  endtask

  task automatic test_all_events();
    logic [63:0] v;
    apply_reset();
    event_i = '1;
    for (int c = 0; c < 100; c++) begin
      csr_idx_i = IdxW'($urandom_range(NumCounters - 1, 0));
      step(1);
    end
    event_i = '0;
    step(6);
    for (int i = 0; i < NumCounters; i++) begin
      read_cnt(i, v);
      n_tests++;
      if (v !== 64'd100) begin
        n_fail++;
        $display("FAIL all_cnt%0d: got %0d expected 100", i, v);
      end
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    event_i     = '0;
    inhibit_i   = '0;
    csr_idx_i   = '0;
    csr_we_i    = 1'b0;
    csr_weh_i   = 1'b0;
    csr_wdata_i = '0;
    ovf_clr_i   = '0;
    step(2);
    rst_i = 1'b0;

    test_reset();
    test_event_accum();
    test_inhibit();
    test_csr_write();
    test_overflow();
    test_all_events();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
